uart_cmd_ctrl: RTL and testbench

Command-framing controller that sits directly behind the UART receiver and sequences it. It consumes each received byte by pulsing the receiver's `clr_rdy`, pairs consecutive bytes into a 16-bit command (high byte first), and presents the command to downstream logic through a ready/clear handshake. It also runs an inter-byte timeout so that a lost second byte cannot permanently misalign framing, and it flags overruns and timeouts.

---
 rtl/uart_cmd_ctrl.sv | 119 +++++++++++
 tb/tb_uart_cmd_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// Command-framing controller behind a UART receiver: pairs received bytes into
// 16-bit commands (high byte first) with an inter-byte timeout and sticky error flags.
module uart_cmd_ctrl #(
    parameter int TIMEOUT = 52080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        clr_err,
    output logic        ovr,
    output logic        tmo
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT - 1);

    localparam logic [0:0] WAIT_HI = 1'b0;
    localparam logic [0:0] WAIT_LO = 1'b1;

    logic [0:0]    state_r;
    logic [7:0]    hi_byte_r;
    logic [CW-1:0] cnt_r;
    logic [15:0]   cmd_r;
    logic          cmd_rdy_r;
    logic          ovr_r;
    logic          tmo_r;

    logic          complete_s;
    logic          timeout_s;

    // Every byte is consumed in the cycle it is presented, in either state.
    assign clr_rdy = rdy;

    // Decode completion and timeout; a byte in the terminal cycle beats the timeout.
    always_comb begin
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        if (state_r == WAIT_LO) begin
            complete_s = rdy;
            timeout_s  = !rdy && (cnt_r == CNT_TERM);
        end else begin
            complete_s = 1'b0;
            timeout_s  = 1'b0;
        end
    end

    // Framing state, captured high byte and inter-byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= WAIT_HI;
            hi_byte_r <= 8'h00;
            cnt_r     <= '0;
        end else begin
            case (state_r)
                WAIT_HI: begin
                    if (rdy) begin
                        hi_byte_r <= rx_data;
                        cnt_r     <= '0;
                        state_r   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (complete_s || timeout_s) begin
                        state_r <= WAIT_HI;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= WAIT_HI;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Command register and its ready flag; completion outranks the downstream clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r     <= 16'h0000;
            cmd_rdy_r <= 1'b0;
        end else if (complete_s) begin
            cmd_r     <= {hi_byte_r, rx_data};
            cmd_rdy_r <= 1'b1;
        end else if (clr_cmd_rdy) begin
            cmd_rdy_r <= 1'b0;
        end
    end

    // Sticky error flags; a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_r <= 1'b0;
            tmo_r <= 1'b0;
        end else begin
            if (complete_s && cmd_rdy_r && !clr_cmd_rdy) begin
                ovr_r <= 1'b1;
            end else if (clr_err) begin
                ovr_r <= 1'b0;
            end
            if (timeout_s) begin
                tmo_r <= 1'b1;
            end else if (clr_err) begin
                tmo_r <= 1'b0;
            end
        end
    end

    assign cmd     = cmd_r;
    assign cmd_rdy = cmd_rdy_r;
    assign ovr     = ovr_r;
    assign tmo     = tmo_r;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level reference model (acceptance-time based timeout).
module tb_uart_cmd_ctrl;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        clr_err = 1'b0;
    logic        ovr;
    logic        tmo;

    int tests = 0;
    int fails = 0;
    int edge_no = 0;

    // Reference model state
    logic        m_have = 1'b0;
    logic [7:0]  m_hi = 8'h00;
    int          m_acc = 0;
    logic [15:0] m_cmd = 16'h0000;
    logic        m_cmd_rdy = 1'b0;
    logic        m_ovr = 1'b0;
    logic        m_tmo = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .clr_err(clr_err),
        .ovr(ovr), .tmo(tmo)
    );

    // Advance one clock edge and apply the same inputs to the model.
    task automatic step();
        logic done;
        logic to;
        done = 1'b0;
        to   = 1'b0;
        @(posedge clk);
        edge_no++;
        if (!rst_n) begin
            m_have = 1'b0; m_cmd = 16'h0000; m_cmd_rdy = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
        end else begin
            if (m_have) begin
                if (rdy) done = 1'b1;
                else if (edge_no - m_acc == TMO) to = 1'b1;
            end else if (rdy) begin
                m_have = 1'b1; m_hi = rx_data; m_acc = edge_no;
            end
            if (done) begin
                if (m_cmd_rdy && !clr_cmd_rdy) m_ovr = 1'b1;
                else if (clr_err) m_ovr = 1'b0;
                m_cmd = {m_hi, rx_data};
                m_cmd_rdy = 1'b1;
                m_have = 1'b0;
            end else begin
                if (clr_cmd_rdy) m_cmd_rdy = 1'b0;
                if (clr_err) m_ovr = 1'b0;
            end
            if (to) begin
                m_tmo = 1'b1;
                m_have = 1'b0;
            end else if (clr_err) begin
                m_tmo = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        rdy = 1'b1; rx_data = b;
        step();
        rdy = 1'b0; rx_data = $urandom_range(0, 255);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_all();
        clr_cmd_rdy = 1'b1; clr_err = 1'b1;
        step();
        clr_cmd_rdy = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        tests++;
        if ({cmd, cmd_rdy, ovr, tmo, clr_rdy} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: cmd=%h cmd_rdy=%b ovr=%b tmo=%b clr_rdy=%b, want all zero",
                     cmd, cmd_rdy, ovr, tmo, clr_rdy);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_normal();
        int pulses;
        pulses = 0;
        rdy = 1'b1; rx_data = 8'hA5; #1;
        if (clr_rdy === 1'b1) pulses++;
        step(); rdy = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (clr_rdy === 1'b1) pulses++;
            step();
        end
        rdy = 1'b1; rx_data = 8'h3C; #1;
        if (clr_rdy === 1'b1) pulses++;
        step(); rdy = 1'b0; #1;
        if (clr_rdy === 1'b1) pulses++;
        tests++;
        if (pulses !== 2) begin
            fails++;
            $display("FAIL normal_clr_rdy: got %0d pulses, want 2", pulses);
        end
        tests++;
        if ({cmd, cmd_rdy, ovr, tmo} !== {16'hA53C, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL normal_cmd: cmd=%h rdy=%b ovr=%b tmo=%b, want a53c 1 0 0", cmd, cmd_rdy, ovr, tmo);
        end
        clr_cmd_rdy = 1'b1; step(); clr_cmd_rdy = 1'b0;
        tests++;
        if (cmd_rdy !== 1'b0) begin
            fails++;
            $display("FAIL normal_clear: cmd_rdy=%b, want 0", cmd_rdy);
        end
    endtask

    task automatic test_timeout();
        drive_byte(8'h12);
        idle(TMO - 1);
        tests++;
        if (tmo !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early: tmo=%b at edge N+99, want 0", tmo);
        end
        step();
        tests++;
        if ({tmo, cmd} !== {1'b1, 16'hA53C}) begin
            fails++;
            $display("FAIL timeout_set: tmo=%b cmd=%h, want 1 a53c", tmo, cmd);
        end
        drive_byte(8'h34);
        drive_byte(8'h56);
        tests++;
        if ({cmd, cmd_rdy} !== {16'h3456, 1'b1}) begin
            fails++;
            $display("FAIL timeout_recover: cmd=%h rdy=%b, want 3456 1", cmd, cmd_rdy);
        end
        clear_all();
        tests++;
        if ({tmo, ovr, cmd_rdy} !== 3'b000) begin
            fails++;
            $display("FAIL timeout_clr_err: tmo=%b ovr=%b rdy=%b, want 000", tmo, ovr, cmd_rdy);
        end
    endtask

    task automatic test_boundary();
        drive_byte(8'h77);
        idle(TMO - 1);
        drive_byte(8'h88);
        tests++;
        if ({cmd, cmd_rdy, tmo} !== {16'h7788, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL boundary_terminal: cmd=%h rdy=%b tmo=%b, want 7788 1 0", cmd, cmd_rdy, tmo);
        end
        clear_all();
        drive_byte(8'h99);
        idle(TMO);
        tests++;
        if ({tmo, cmd} !== {1'b1, 16'h7788}) begin
            fails++;
            $display("FAIL boundary_late_tmo: tmo=%b cmd=%h, want 1 7788", tmo, cmd);
        end
        drive_byte(8'hAA);
        tests++;
        if ({cmd, cmd_rdy} !== {16'h7788, 1'b0}) begin
            fails++;
            $display("FAIL boundary_late_hi: cmd=%h rdy=%b, want 7788 0", cmd, cmd_rdy);
        end
        drive_byte(8'hBB);
        tests++;
        if ({cmd, cmd_rdy} !== {16'hAABB, 1'b1}) begin
            fails++;
            $display("FAIL boundary_late_cmd: cmd=%h rdy=%b, want aabb 1", cmd, cmd_rdy);
        end
        clear_all();
    endtask

    task automatic test_overrun();
        drive_byte(8'h11); drive_byte(8'h11);
        drive_byte(8'h22); drive_byte(8'h22);
        tests++;
        if ({ovr, cmd, cmd_rdy} !== {1'b1, 16'h2222, 1'b1}) begin
            fails++;
            $display("FAIL overrun_set: ovr=%b cmd=%h rdy=%b, want 1 2222 1", ovr, cmd, cmd_rdy);
        end
        clr_err = 1'b1; step(); clr_err = 1'b0;
        tests++;
        if (ovr !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clear: ovr=%b, want 0", ovr);
        end
        clear_all();
    endtask

    task automatic test_back_to_back();
        drive_byte(8'hC0); drive_byte(8'hDE);
        clr_cmd_rdy = 1'b1; drive_byte(8'hBE);
        rdy = 1'b1; rx_data = 8'hEF;
        step();
        rdy = 1'b0; clr_cmd_rdy = 1'b0;
        tests++;
        if ({cmd_rdy, ovr, cmd} !== {1'b1, 1'b0, 16'hBEEF}) begin
            fails++;
            $display("FAIL simul_clear: rdy=%b ovr=%b cmd=%h, want 1 0 beef", cmd_rdy, ovr, cmd);
        end
        drive_byte(8'h01);
        rdy = 1'b1; rx_data = 8'h02; clr_err = 1'b1;
        step();
        rdy = 1'b0; clr_err = 1'b0;
        tests++;
        if ({ovr, cmd} !== {1'b1, 16'h0102}) begin
            fails++;
            $display("FAIL simul_clr_err: ovr=%b cmd=%h, want 1 0102", ovr, cmd);
        end
        clear_all();
    endtask

    task automatic test_reset_mid();
        drive_byte(8'h5A); drive_byte(8'h5B);
        drive_byte(8'hFF);
        rst_n = 1'b0; #1;
        tests++;
        if ({cmd, cmd_rdy, ovr, tmo, clr_rdy} !== {16'h0000, 4'b0000}) begin
            fails++;
            $display("FAIL reset_async: cmd=%h rdy=%b ovr=%b tmo=%b, want 0000 0 0 0", cmd, cmd_rdy, ovr, tmo);
        end
        idle(3);
        tests++;
        if ({cmd, cmd_rdy, ovr, tmo} !== {16'h0000, 3'b000}) begin
            fails++;
            $display("FAIL reset_hold: cmd=%h rdy=%b ovr=%b tmo=%b, want 0000 0 0 0", cmd, cmd_rdy, ovr, tmo);
        end
        rst_n = 1'b1;
        drive_byte(8'h01); drive_byte(8'h02);
        tests++;
        if ({cmd, cmd_rdy} !== {16'h0102, 1'b1}) begin
            fails++;
            $display("FAIL reset_mid_cmd: cmd=%h rdy=%b, want 0102 1", cmd, cmd_rdy);
        end
        clear_all();
    endtask

    task automatic test_random();
        int prob;
        logic prev_rdy;
        prev_rdy = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            prob = ((i / 300) % 2 == 0) ? 20 : 1;
            rdy = !prev_rdy && ($urandom_range(0, 99) < prob);
            rx_data = $urandom_range(0, 255);
            clr_cmd_rdy = ($urandom_range(0, 9) == 0);
            clr_err = ($urandom_range(0, 29) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
            prev_rdy = rdy;
            #1;
            tests++;
            if (clr_rdy !== rdy) begin
                fails++;
                $display("FAIL rand_clr_rdy: cycle %0d clr_rdy=%b, want %b", i, clr_rdy, rdy);
            end
            step();
            tests++;
            if ({cmd, cmd_rdy, ovr, tmo} !== {m_cmd, m_cmd_rdy, m_ovr, m_tmo}) begin
                fails++;
                $display("FAIL rand_model: cycle %0d cmd=%h rdy=%b ovr=%b tmo=%b, want %h %b %b %b",
                         i, cmd, cmd_rdy, ovr, tmo, m_cmd, m_cmd_rdy, m_ovr, m_tmo);
            end
        end
        rst_n = 1'b1; rdy = 1'b0; clr_cmd_rdy = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_boundary();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
